// File: rtl/capture_pkg.sv
// Shared types and constants for the camera capture frame sequencer.
// Holds the resolution/state encodings, register map offsets and frame sizes.
package capture_pkg;

  typedef enum logic [1:0] {
    RES_VGA     = 2'b00,
    RES_XGA     = 2'b01,
    RES_SXGA    = 2'b10,
    RES_VGA_ALT = 2'b11
  } resol_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACTIVE,
    ST_DONE
  } cap_state_t;

  localparam logic [15:0] OFF_CAPADDR = 16'h0000;
  localparam logic [15:0] OFF_CAPCTRL = 16'h0004;
  localparam logic [15:0] OFF_CAPINT  = 16'h0008;
  localparam logic [15:0] OFF_CAPFIFO = 16'h000C;

  localparam int unsigned CAPINT_IRQEN  = 0;
  localparam int unsigned CAPINT_CBLANK = 1;
  localparam int unsigned CAPINT_FERR   = 2;
  localparam logic [31:0] CBLANK_MASK   = 32'h0000_0002;

  localparam logic [20:0] PIX_VGA  = 21'd307200;
  localparam logic [20:0] PIX_XGA  = 21'd786432;
  localparam logic [20:0] PIX_SXGA = 21'd1310720;

  function automatic logic [20:0] pix_count(input resol_t r);
    case (r)
      RES_XGA:  return PIX_XGA;
      RES_SXGA: return PIX_SXGA;
      default:  return PIX_VGA;
    endcase
  endfunction

endpackage

// File: rtl/capture_regs.sv
// Register block for the capture path: CAPADDR/CAPCTRL/CAPINT/CAPFIFO decode,
// W1C sticky status bits and the registered read-data mux.
module capture_regs
  import capture_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h1000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_wraddr,
  input  logic [3:0]  i_byteen,
  input  logic        i_wren,
  input  logic [31:0] i_wdata,
  input  logic [15:0] i_rdaddr,
  input  logic        i_rden,
  input  logic        i_set_cblank,
  input  logic        i_set_ferr,
  input  logic        i_fifo_over,
  input  logic        i_fifo_under,
  output logic [31:0] o_rdata,
  output logic [31:0] o_capaddr,
  output logic        o_capon,
  output logic        o_cap_irq
);

  logic [31:0] r_capaddr;
  logic        r_capon;
  logic        r_irqen;
  logic        r_cblank;
  logic        r_ferr;
  logic        r_over;
  logic        r_under;
  logic [31:0] r_rdata;

  logic        w_wsel_addr, w_wsel_ctrl, w_wsel_int, w_wsel_fifo;
  logic        w_clr_cblank, w_clr_ferr, w_clr_over, w_clr_under;
  logic [31:0] w_rdmux;

  assign w_wsel_addr = i_wren && (i_wraddr == BASE_ADDR + OFF_CAPADDR);
  assign w_wsel_ctrl = i_wren && (i_wraddr == BASE_ADDR + OFF_CAPCTRL);
  assign w_wsel_int  = i_wren && (i_wraddr == BASE_ADDR + OFF_CAPINT);
  assign w_wsel_fifo = i_wren && (i_wraddr == BASE_ADDR + OFF_CAPFIFO);

  assign w_clr_cblank = w_wsel_int  && i_byteen[0] && (|(i_wdata & CBLANK_MASK));
  assign w_clr_ferr   = w_wsel_int  && i_byteen[0] && i_wdata[CAPINT_FERR];
  assign w_clr_over   = w_wsel_fifo && i_byteen[0] && i_wdata[0];
  assign w_clr_under  = w_wsel_fifo && i_byteen[0] && i_wdata[1];

  always_comb begin
    w_rdmux = '0;
    if (i_rdaddr == BASE_ADDR + OFF_CAPADDR) begin
      w_rdmux = r_capaddr;
    end else if (i_rdaddr == BASE_ADDR + OFF_CAPCTRL) begin
      w_rdmux[0] = r_capon;
    end else if (i_rdaddr == BASE_ADDR + OFF_CAPINT) begin
      w_rdmux[CAPINT_IRQEN]  = r_irqen;
      w_rdmux[CAPINT_CBLANK] = r_cblank;
      w_rdmux[CAPINT_FERR]   = r_ferr;
    end else if (i_rdaddr == BASE_ADDR + OFF_CAPFIFO) begin
      w_rdmux[1:0] = {r_under, r_over};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_capaddr <= '0;
      r_capon   <= 1'b0;
      r_irqen   <= 1'b0;
      r_cblank  <= 1'b0;
      r_ferr    <= 1'b0;
      r_over    <= 1'b0;
      r_under   <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_wsel_addr) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (i_byteen[b]) r_capaddr[b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
      if (w_wsel_ctrl && i_byteen[0]) r_capon <= i_wdata[0];
      if (w_wsel_int  && i_byteen[0]) r_irqen <= i_wdata[CAPINT_IRQEN];
      // hardware set beats a same-cycle W1C
      r_cblank <= i_set_cblank | (r_cblank & ~w_clr_cblank);
      r_ferr   <= i_set_ferr   | (r_ferr   & ~w_clr_ferr);
      r_over   <= i_fifo_over  | (r_over   & ~w_clr_over);
      r_under  <= i_fifo_under | (r_under  & ~w_clr_under);
      if (i_rden) r_rdata <= w_rdmux;
    end
  end

  assign o_rdata   = r_rdata;
  assign o_capaddr = r_capaddr;
  assign o_capon   = r_capon;
  assign o_cap_irq = r_cblank & r_irqen;

endmodule

// File: rtl/capture_frame_ctrl.sv
// Frame-level capture sequencer: waits for a VSYNC fall, gates whole frames into
// the write path and flags CBLANK/FRAME_ERR. FRAME_DIV_LOG2 scales frame sizes (0 = real).
module capture_frame_ctrl
  import capture_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR      = 16'h1000,
  parameter int unsigned CNT_W          = 21,
  parameter int unsigned FRAME_DIV_LOG2 = 0
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [1:0]  RESOL,
  input  logic        VSYNC,
  input  logic        PIX_VALID,
  input  logic        FIFO_OVER,
  input  logic        FIFO_UNDER,
  input  logic [15:0] WRADDR,
  input  logic [3:0]  BYTEEN,
  input  logic        WREN,
  input  logic [31:0] WDATA,
  input  logic [15:0] RDADDR,
  input  logic        RDEN,
  output logic [31:0] RDATA,
  output logic        CAP_EN,
  output logic        FRAME_START,
  output logic [31:0] FRAME_BASE,
  output logic        CAP_IRQ
);

  cap_state_t       r_state;
  logic             r_vs, r_vs_d;
  logic             r_cap_en;
  logic             r_frame_start;
  logic [31:0]      r_frame_base;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_expected;
  logic             r_set_cblank;
  logic             r_set_ferr;

  logic             w_vs_fall, w_vs_rise, w_last;
  logic             w_capon;
  logic [31:0]      w_capaddr;
  logic [CNT_W-1:0] w_expected;

  assign w_vs_fall  = r_vs_d & ~r_vs;
  assign w_vs_rise  = ~r_vs_d & r_vs;
  assign w_expected = CNT_W'(pix_count(resol_t'(RESOL)) >> FRAME_DIV_LOG2);
  assign w_last     = PIX_VALID && (r_pix_cnt == r_expected - CNT_W'(1));

  capture_regs #(.BASE_ADDR(BASE_ADDR)) u_regs (
    .i_clk        (ACLK),
    .i_rst        (ARESET),
    .i_wraddr     (WRADDR),
    .i_byteen     (BYTEEN),
    .i_wren       (WREN),
    .i_wdata      (WDATA),
    .i_rdaddr     (RDADDR),
    .i_rden       (RDEN),
    .i_set_cblank (r_set_cblank),
    .i_set_ferr   (r_set_ferr),
    .i_fifo_over  (FIFO_OVER),
    .i_fifo_under (FIFO_UNDER),
    .o_rdata      (RDATA),
    .o_capaddr    (w_capaddr),
    .o_capon      (w_capon),
    .o_cap_irq    (CAP_IRQ)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state       <= ST_IDLE;
      r_vs          <= 1'b0;
      r_vs_d        <= 1'b0;
      r_cap_en      <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_base  <= '0;
      r_pix_cnt     <= '0;
      r_expected    <= '0;
      r_set_cblank  <= 1'b0;
      r_set_ferr    <= 1'b0;
    end else begin
      r_vs          <= VSYNC;
      r_vs_d        <= r_vs;
      r_frame_start <= 1'b0;
      r_set_cblank  <= 1'b0;
      r_set_ferr    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_capon) r_state <= ST_SYNC;
        end
        ST_SYNC: begin
          if (!w_capon) begin
            r_state <= ST_IDLE;
          end else if (w_vs_fall) begin
            r_state       <= ST_ACTIVE;
            r_cap_en      <= 1'b1;
            r_frame_start <= 1'b1;
            r_frame_base  <= w_capaddr;
            r_pix_cnt     <= '0;
            r_expected    <= w_expected;
          end
        end
        ST_ACTIVE: begin
          // a last pixel coinciding with vs_rise still counts as a whole frame
          if (w_last) begin
            r_cap_en <= 1'b0;
            if (w_vs_rise) begin
              r_set_cblank <= 1'b1;
              r_state      <= w_capon ? ST_SYNC : ST_IDLE;
            end else begin
              r_state <= ST_DONE;
            end
          end else if (w_vs_rise) begin
            r_cap_en   <= 1'b0;
            r_set_ferr <= 1'b1;
            r_state    <= ST_SYNC;
          end else if (PIX_VALID) begin
            r_pix_cnt <= r_pix_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (w_vs_rise) begin
            r_set_cblank <= 1'b1;
            r_state      <= w_capon ? ST_SYNC : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign CAP_EN      = r_cap_en;
  assign FRAME_START = r_frame_start;
  assign FRAME_BASE  = r_frame_base;

endmodule

// File: tb/tb_capture_frame_ctrl.sv
// Directed bench for capture_frame_ctrl with scaled frame sizes (VGA=4800, XGA=12288).
module tb_capture_frame_ctrl;

  localparam logic [15:0] BASE = 16'h1000;

  logic        ACLK = 1'b0;
  logic        ARESET, VSYNC, PIX_VALID, FIFO_OVER, FIFO_UNDER, WREN, RDEN;
  logic [1:0]  RESOL;
  logic [15:0] WRADDR, RDADDR;
  logic [3:0]  BYTEEN;
  logic [31:0] WDATA, RDATA, FRAME_BASE;
  logic        CAP_EN, FRAME_START, CAP_IRQ;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [31:0] rq[$];
  logic [31:0] bq[$];
  logic        seen;

  always #5 ACLK = ~ACLK;

  capture_frame_ctrl #(.BASE_ADDR(BASE), .CNT_W(21), .FRAME_DIV_LOG2(6)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .RESOL(RESOL), .VSYNC(VSYNC), .PIX_VALID(PIX_VALID),
    .FIFO_OVER(FIFO_OVER), .FIFO_UNDER(FIFO_UNDER), .WRADDR(WRADDR), .BYTEEN(BYTEEN),
    .WREN(WREN), .WDATA(WDATA), .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
    .CAP_EN(CAP_EN), .FRAME_START(FRAME_START), .FRAME_BASE(FRAME_BASE), .CAP_IRQ(CAP_IRQ)
  );

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] off, input logic [31:0] d, input logic [3:0] be);
    WRADDR = BASE + off; WDATA = d; BYTEEN = be; WREN = 1'b1;
    tick();
    WREN = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [15:0] off, input logic [31:0] exp);
    rq.push_back(exp);
    RDADDR = BASE + off; RDEN = 1'b1;
    tick();
    RDEN = 1'b0;
    chk(tag, RDATA, rq.pop_front());
  endtask

  task automatic pix(input int unsigned n);
    PIX_VALID = 1'b1;
    repeat (n) tick();
    PIX_VALID = 1'b0;
  endtask

  task automatic start_frame(input string tag, input logic [31:0] exp_base);
    bq.push_back(exp_base);
    VSYNC = 1'b0;
    tick();
    chk({tag, "_fs_early"}, 32'(FRAME_START), 32'd0);
    tick();
    chk({tag, "_fs"}, 32'(FRAME_START), 32'd1);
    chk({tag, "_cap_en_on"}, 32'(CAP_EN), 32'd1);
    chk({tag, "_base"}, FRAME_BASE, bq.pop_front());
  endtask

  task automatic full_frame(input string tag, input int unsigned n);
    pix(n - 1);
    chk({tag, "_cap_en_prelast"}, 32'(CAP_EN), 32'd1);
    pix(1);
    chk({tag, "_cap_en_off"}, 32'(CAP_EN), 32'd0);
    pix(3);
    chk({tag, "_extra_ignored"}, 32'(CAP_EN), 32'd0);
  endtask

  task automatic end_frame();
    VSYNC = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    ARESET = 1'b1; VSYNC = 1'b1; PIX_VALID = 1'b0; FIFO_OVER = 1'b0; FIFO_UNDER = 1'b0;
    WREN = 1'b0; RDEN = 1'b0; RESOL = 2'b00; WRADDR = '0; RDADDR = '0; BYTEEN = '0; WDATA = '0;
    repeat (3) tick();
    ARESET = 1'b0;
    tick();
    chk("rst_cap_en", 32'(CAP_EN), 32'd0);
    chk("rst_fs", 32'(FRAME_START), 32'd0);
    chk("rst_base", FRAME_BASE, 32'd0);
    chk("rst_irq", 32'(CAP_IRQ), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);
    rd_chk("rst_capaddr", 16'h0, 32'd0);
    rd_chk("rst_capint", 16'h8, 32'd0);
    wr(16'h10, 32'hFFFF_FFFF, 4'hF);
    rd_chk("unmapped", 16'h10, 32'd0);

    // T1: CAPON mid-frame waits for the next vs_fall
    wr(16'h0, 32'h1111_0000, 4'hF);
    wr(16'h8, 32'h1, 4'hF);
    VSYNC = 1'b0;
    pix(20);
    wr(16'h4, 32'h1, 4'hF);
    pix(50);
    chk("t1_no_partial", 32'(CAP_EN), 32'd0);
    end_frame();
    start_frame("t1", 32'h1111_0000);
    full_frame("t1", 4800);
    end_frame();
    rd_chk("t1_cblank", 16'h8, 32'h3);
    chk("t1_irq", 32'(CAP_IRQ), 32'd1);
    wr(16'h8, 32'h3, 4'hF);
    rd_chk("t1_w1c", 16'h8, 32'h1);
    chk("t1_irq_clr", 32'(CAP_IRQ), 32'd0);

    // T2: early VSYNC rise -> FRAME_ERR, then a clean frame
    start_frame("t2a", 32'h1111_0000);
    pix(1000);
    end_frame();
    chk("t2_cap_en", 32'(CAP_EN), 32'd0);
    rd_chk("t2_ferr", 16'h8, 32'h5);
    wr(16'h8, 32'h5, 4'hF);
    rd_chk("t2_ferr_clr", 16'h8, 32'h1);
    start_frame("t2b", 32'h1111_0000);
    full_frame("t2b", 4800);
    end_frame();
    rd_chk("t2_cblank", 16'h8, 32'h3);
    wr(16'h8, 32'h3, 4'hF);

    // T3: CAPADDR/RESOL changes mid-frame apply to the next frame
    wr(16'h0, 32'h2000_0000, 4'hF);
    start_frame("t3a", 32'h2000_0000);
    pix(100);
    wr(16'h0, 32'h2010_0000, 4'hF);
    RESOL = 2'b01;
    chk("t3_base_hold", FRAME_BASE, 32'h2000_0000);
    full_frame("t3a", 4700);
    end_frame();
    wr(16'h8, 32'h3, 4'hF);
    start_frame("t3b", 32'h2010_0000);
    RESOL = 2'b00;
    full_frame("t3b_xga", 12288);
    end_frame();
    wr(16'h8, 32'h3, 4'hF);

    // T4: CAPON cleared in ACTIVE -> graceful stop
    start_frame("t4", 32'h2010_0000);
    pix(10);
    wr(16'h4, 32'h0, 4'hF);
    full_frame("t4", 4790);
    end_frame();
    rd_chk("t4_cblank", 16'h8, 32'h3);
    chk("t4_irq", 32'(CAP_IRQ), 32'd1);
    rd_chk("t4_capon", 16'h4, 32'h0);
    VSYNC = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen = seen | FRAME_START | CAP_EN;
    end
    chk("t4_stays_idle", 32'(seen), 32'd0);
    end_frame();

    // T5: sticky FIFO flags, set beats W1C
    WRADDR = BASE + 16'hC; WDATA = 32'h1; BYTEEN = 4'hF; WREN = 1'b1; FIFO_OVER = 1'b1;
    tick();
    WREN = 1'b0; FIFO_OVER = 1'b0;
    rd_chk("t5_set_wins", 16'hC, 32'h1);
    FIFO_UNDER = 1'b1;
    tick();
    FIFO_UNDER = 1'b0;
    rd_chk("t5_under", 16'hC, 32'h3);
    wr(16'hC, 32'h1, 4'h0);
    rd_chk("t5_be0", 16'hC, 32'h3);
    wr(16'hC, 32'h1, 4'hF);
    rd_chk("t5_over_clr", 16'hC, 32'h2);
    wr(16'hC, 32'h2, 4'hF);
    rd_chk("t5_under_clr", 16'hC, 32'h0);

    // same-cycle read and write return the old value; partial byte enables
    rq.push_back(32'h2010_0000);
    WRADDR = BASE; WDATA = 32'hDEAD_BEEF; BYTEEN = 4'hF; WREN = 1'b1;
    RDADDR = BASE; RDEN = 1'b1;
    tick();
    WREN = 1'b0; RDEN = 1'b0;
    chk("rw_old", RDATA, rq.pop_front());
    rd_chk("rw_new", 16'h0, 32'hDEAD_BEEF);
    wr(16'h0, 32'h1234_5678, 4'b0101);
    rd_chk("byteen", 16'h0, 32'hDE34_BE78);

    // T6: reset mid-frame
    wr(16'h4, 32'h1, 4'hF);
    start_frame("t6", 32'hDE34_BE78);
    pix(100);
    FIFO_OVER = 1'b1;
    tick();
    FIFO_OVER = 1'b0;
    rd_chk("t6_pre_rd", 16'h0, 32'hDE34_BE78);
    chk("t6_pre_irq", 32'(CAP_IRQ), 32'd1);
    ARESET = 1'b1;
    tick();
    chk("t6_cap_en", 32'(CAP_EN), 32'd0);
    chk("t6_rdata", RDATA, 32'd0);
    chk("t6_base", FRAME_BASE, 32'd0);
    chk("t6_irq", 32'(CAP_IRQ), 32'd0);
    ARESET = 1'b0;
    rd_chk("t6_capaddr", 16'h0, 32'd0);
    rd_chk("t6_capctrl", 16'h4, 32'd0);
    rd_chk("t6_capint", 16'h8, 32'd0);
    rd_chk("t6_capfifo", 16'hC, 32'd0);
    wr(16'h4, 32'h1, 4'hF);
    pix(30);
    chk("t6_wait_sync", 32'(CAP_EN), 32'd0);
    end_frame();
    start_frame("t6b", 32'd0);
    pix(10);
    chk("t6b_cap_en", 32'(CAP_EN), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
